// File: rtl/kd_tree_pkg.sv
// Shared constants and node-word layout for the k-d tree traversal pipeline.
package kd_tree_pkg;

    localparam int unsigned DIM_WIDTH  = 11;
    localparam int unsigned NUM_DIMS   = 5;
    localparam int unsigned TREE_DEPTH = 6;
    localparam int unsigned NUM_NODES  = 63;

    // Node word: {median[21:11], dim[10:0]}
    localparam int unsigned DIM_LSB    = 0;
    localparam int unsigned MEDIAN_LSB = DIM_WIDTH;

    localparam int unsigned PTR_WIDTH  = 6;
    localparam int unsigned SEL_WIDTH  = 3;

    // Out-of-range dimension selects fall back to component 0.
    function automatic logic [SEL_WIDTH-1:0] dim_to_sel(input logic [DIM_WIDTH-1:0] dim);
        return (dim < DIM_WIDTH'(NUM_DIMS)) ? SEL_WIDTH'(dim) : '0;
    endfunction

endpackage

// File: rtl/tree_level_stage.sv
// One tree level: look up the current node, compare the selected patch component
// against its median and register the extended path with the forwarded patch.
module tree_level_stage
    import kd_tree_pkg::*;
#(
    parameter int unsigned LEVEL          = 0,
    parameter int unsigned INTERNAL_WIDTH = 22,
    parameter int unsigned PATCH_WIDTH    = 55
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  valid_i,
    input  logic [PATCH_WIDTH-1:0]                patch_i,
    input  logic [TREE_DEPTH-1:0]                 path_i,
    input  logic [(1<<LEVEL)*INTERNAL_WIDTH-1:0]  level_nodes_i,
    output logic                                  valid_o,
    output logic [PATCH_WIDTH-1:0]                patch_o,
    output logic [TREE_DEPTH-1:0]                 path_o
);

    localparam int unsigned NodeCount = 1 << LEVEL;

    logic [INTERNAL_WIDTH-1:0]   node_word;
    logic [DIM_WIDTH-1:0]        dim;
    logic [SEL_WIDTH-1:0]        sel;
    logic signed [DIM_WIDTH-1:0] median;
    logic signed [DIM_WIDTH-1:0] component;
    logic                        go_right;
    logic [TREE_DEPTH-1:0]       path_d;

    logic                        valid_q;
    logic [PATCH_WIDTH-1:0]      patch_q;
    logic [TREE_DEPTH-1:0]       path_q;

    // Node lookup within this level, component select and signed compare.
    always_comb begin
        node_word = '0;
        for (int i = 0; i < NodeCount; i++) begin
            if (path_i == TREE_DEPTH'(i)) begin
                node_word = level_nodes_i[i*INTERNAL_WIDTH +: INTERNAL_WIDTH];
            end
        end
        dim    = node_word[DIM_LSB +: DIM_WIDTH];
        median = node_word[MEDIAN_LSB +: DIM_WIDTH];
        sel    = dim_to_sel(dim);
        component = '0;
        for (int k = 0; k < NUM_DIMS; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                component = patch_i[PATCH_WIDTH-1-k*DIM_WIDTH -: DIM_WIDTH];
            end
        end
        // Ties go left.
        go_right = component > median;
        path_d   = {path_i[TREE_DEPTH-2:0], go_right};
    end

    // Pipeline register; payload only moves with a valid patch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            patch_q <= '0;
            path_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                patch_q <= patch_i;
                path_q  <= path_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign patch_o = patch_q;
    assign path_o  = path_q;

endmodule

// File: rtl/internal_node_tree.sv
// Depth-6 k-d tree of 63 internal nodes loaded breadth-first, traversed by a
// six-stage pipeline accepting one patch per cycle.
module internal_node_tree
    import kd_tree_pkg::*;
#(
    parameter int unsigned INTERNAL_WIDTH = 22,
    parameter int unsigned PATCH_WIDTH    = 55,
    parameter int unsigned ADDRESS_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fsm_enable,
    input  logic                      sender_enable,
    input  logic [INTERNAL_WIDTH-1:0] sender_data,
    input  logic                      patch_en,
    input  logic [PATCH_WIDTH-1:0]    patch_in,
    output logic [ADDRESS_WIDTH-1:0]  leaf_index,
    output logic                      receiver_en
);

    logic [INTERNAL_WIDTH-1:0] nodes_q [NUM_NODES];
    logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic                      wr_en;

    logic                      stage_valid [TREE_DEPTH+1];
    logic [PATCH_WIDTH-1:0]    stage_patch [TREE_DEPTH+1];
    logic [TREE_DEPTH-1:0]     stage_path  [TREE_DEPTH+1];

    logic [ADDRESS_WIDTH-1:0]  leaf_q, leaf_d;
    logic                      rx_q;

    // Writes stop for good once the pointer reaches NUM_NODES.
    always_comb begin
        wr_en    = fsm_enable && sender_enable && (wr_ptr_q != PTR_WIDTH'(NUM_NODES));
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
    end

    // Node storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                nodes_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                nodes_q[wr_ptr_q] <= sender_data;
            end
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign stage_valid[0] = patch_en;
    assign stage_patch[0] = patch_in;
    assign stage_path[0]  = '0;

    for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_level
        localparam int unsigned First = (1 << l) - 1;
        localparam int unsigned Count = 1 << l;

        logic [Count*INTERNAL_WIDTH-1:0] level_nodes;

        for (genvar i = 0; i < Count; i++) begin : g_node
            assign level_nodes[i*INTERNAL_WIDTH +: INTERNAL_WIDTH] = nodes_q[First+i];
        end

        tree_level_stage #(
            .LEVEL          (l),
            .INTERNAL_WIDTH (INTERNAL_WIDTH),
            .PATCH_WIDTH    (PATCH_WIDTH)
        ) u_stage (
            .clk           (clk),
            .rst_n         (rst_n),
            .valid_i       (stage_valid[l]),
            .patch_i       (stage_patch[l]),
            .path_i        (stage_path[l]),
            .level_nodes_i (level_nodes),
            .valid_o       (stage_valid[l+1]),
            .patch_o       (stage_patch[l+1]),
            .path_o        (stage_path[l+1])
        );
    end

    assign leaf_d = ADDRESS_WIDTH'(stage_path[TREE_DEPTH]);

    // Output register: strobe for one cycle, index held between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf_q <= '0;
            rx_q   <= 1'b0;
        end else begin
            rx_q <= stage_valid[TREE_DEPTH];
            if (stage_valid[TREE_DEPTH]) begin
                leaf_q <= leaf_d;
            end
        end
    end

    assign leaf_index  = leaf_q;
    assign receiver_en = rx_q;

endmodule

// File: tb/tb_internal_node_tree.sv
// Self-checking bench for internal_node_tree: directed tree/patch cases plus
// randomized loads and patches scored against a walk-the-tree reference model.
module tb_internal_node_tree;

    logic        clk;
    logic        rst_n;
    logic        fsm_enable;
    logic        sender_enable;
    logic [21:0] sender_data;
    logic        patch_en;
    logic [54:0] patch_in;
    logic [7:0]  leaf_index;
    logic        receiver_en;

    internal_node_tree dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fsm_enable    (fsm_enable),
        .sender_enable (sender_enable),
        .sender_data   (sender_data),
        .patch_en      (patch_en),
        .patch_in      (patch_in),
        .leaf_index    (leaf_index),
        .receiver_en   (receiver_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [21:0] nodes_m [63];
    int          wr_ptr_m = 0;
    bit          exp_rx   [4096];
    int          exp_leaf [4096];
    logic [7:0]  last_leaf = 8'd0;
    int          cyc = 0;

    function automatic logic [54:0] mk_patch(input int c0, input int c1, input int c2,
                                             input int c3, input int c4);
        return {11'(c0), 11'(c1), 11'(c2), 11'(c3), 11'(c4)};
    endfunction

    function automatic logic [21:0] mk_word(input int med, input int dim);
        return {11'(med), 11'(dim)};
    endfunction

    // Walk node numbers from the root until a leaf number (>= 63) is reached.
    function automatic int model_leaf(input logic [54:0] p);
        int n = 0;
        int k;
        logic [10:0] d;
        logic signed [10:0] m;
        logic signed [10:0] c;
        while (n < 63) begin
            d = nodes_m[n][10:0];
            m = nodes_m[n][21:11];
            k = (d <= 11'd4) ? int'(d) : 0;
            c = p[54-11*k -: 11];
            n = (c <= m) ? 2*n + 1 : 2*n + 2;
        end
        return n - 63;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 63; i++) nodes_m[i] = '0;
        wr_ptr_m = 0;
        for (int i = cyc; i < cyc + 8; i++) exp_rx[i] = 1'b0;
        last_leaf = 8'd0;
    endtask

    // Drive one cycle, update the model, then check outputs just after the edge.
    task automatic tick(input bit fe, input bit we, input logic [21:0] wd,
                        input bit pe, input logic [54:0] pd);
        fsm_enable    = fe;
        sender_enable = we;
        sender_data   = wd;
        patch_en      = pe;
        patch_in      = pd;
        if (pe && rst_n) begin
            exp_rx[cyc+6]   = 1'b1;
            exp_leaf[cyc+6] = model_leaf(pd);
        end
        if (fe && we && rst_n && wr_ptr_m < 63) begin
            nodes_m[wr_ptr_m] = wd;
            wr_ptr_m++;
        end
        @(posedge clk);
        #1;
        if (exp_rx[cyc]) last_leaf = 8'(exp_leaf[cyc]);
        checks++;
        assert (receiver_en === exp_rx[cyc])
        else begin
            failures++;
            $error("FAIL receiver_en cyc=%0d got=%b exp=%b", cyc, receiver_en, exp_rx[cyc]);
        end
        checks++;
        assert (leaf_index === last_leaf)
        else begin
            failures++;
            $error("FAIL leaf_index cyc=%0d got=%0d exp=%0d", cyc, leaf_index, last_leaf);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [54:0] rand_patch();
        return mk_patch(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                        int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                        int'($urandom_range(0, 400)) - 200);
    endfunction

    function automatic logic [21:0] rand_word();
        int dim;
        dim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                          : int'($urandom_range(0, 5));
        return mk_word(int'($urandom_range(0, 400)) - 200, dim);
    endfunction

    initial begin
        rst_n         = 1'b0;
        fsm_enable    = 1'b0;
        sender_enable = 1'b0;
        sender_data   = '0;
        patch_en      = 1'b0;
        patch_in      = '0;
        model_reset();

        // Reset state.
        #3;
        checks++;
        assert (leaf_index === 8'd0)
        else begin
            failures++;
            $error("FAIL reset_leaf got=%0d exp=0", leaf_index);
        end
        checks++;
        assert (receiver_en === 1'b0)
        else begin
            failures++;
            $error("FAIL reset_rx got=%b exp=0", receiver_en);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // All-zero tree: +5 right, -5 left, back-to-back, then a tie.
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(5, 0, 0, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(-5, 0, 0, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(5, 0, 0, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(0, 0, 0, 0, 0));
        idle(8);

        // Root {100, dim 2}, rest zero.
        for (int i = 0; i < 63; i++) begin
            tick(1'b1, 1'b1, (i == 0) ? mk_word(100, 2) : 22'd0, 1'b0, '0);
        end
        idle(1);
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(0, 0, 101, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(1, 0, 100, 0, 0));
        idle(8);

        // Reset with two patches in flight.
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(0, 0, 101, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b1, mk_patch(1, 0, 100, 0, 0));
        tick(1'b0, 1'b0, '0, 1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        assert (leaf_index === 8'd0)
        else begin
            failures++;
            $error("FAIL midreset_leaf got=%0d exp=0", leaf_index);
        end
        checks++;
        assert (receiver_en === 1'b0)
        else begin
            failures++;
            $error("FAIL midreset_rx got=%b exp=0", receiver_en);
        end
        idle(2);
        rst_n = 1'b1;
        idle(8);

        // Reload 70 random words; only the first 63 land.
        for (int i = 0; i < 70; i++) tick(1'b1, 1'b1, rand_word(), 1'b0, '0);
        idle(2);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, '0, ($urandom_range(0, 3) != 0), rand_patch());
        end
        idle(8);

        // Writes with the load phase disabled must not disturb the tree.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, rand_word(), 1'b0, '0);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, ($urandom_range(0, 1) == 1), rand_word(),
                 ($urandom_range(0, 3) != 0), rand_patch());
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/internal_node_tree.md
INTERNAL_NODE_TREE -- requirements
Module: internal_node_tree

Interface
REQ-001 SHALL have parameter INTERNAL_WIDTH, default 22: width of one internal-node word, {median[21:11], dim[10:0]}.
REQ-002 SHALL have parameter PATCH_WIDTH, default 55: five 11-bit signed components.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 8: width of leaf_index.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port fsm_enable, input, 1 bit: load phase enable; node writes are accepted only when it is high.
REQ-007 SHALL have port sender_enable, input, 1 bit: node word valid this cycle.
REQ-008 SHALL have port sender_data, input, INTERNAL_WIDTH bits: node word.
REQ-009 SHALL have port patch_en, input, 1 bit: patch valid this cycle.
REQ-010 SHALL have port patch_in, input, PATCH_WIDTH bits: component k at bits [54-11k : 44-11k], k=0..4, two's complement.
REQ-011 SHALL have port leaf_index, output, ADDRESS_WIDTH bits: leaf reached, 0..63, zero-extended.
REQ-012 SHALL have port receiver_en, output, 1 bit: leaf_index valid strobe.

Function
REQ-013 SHALL store 63 internal nodes (depth 6) in breadth-first order; node n has children 2n+1 and 2n+2.
REQ-014 SHALL write sender_data to node[wr_ptr] and increment wr_ptr on each cycle where fsm_enable and sender_enable are both high.
REQ-015 SHALL ignore writes once wr_ptr reaches 63; wr_ptr does not wrap.
REQ-016 SHALL hold wr_ptr and stored nodes while fsm_enable is low.
REQ-017 SHALL take the dimension select from the low 11 bits of the node word, unsigned; a value above 4 selects component 0.
REQ-018 SHALL take the median from the high 11 bits of the node word, signed.
REQ-019 SHALL, at each level, go left (path bit 0) if patch[dim] <= median, using a signed 11-bit compare; otherwise go right (path bit 1).
REQ-020 SHALL form leaf_index as the six path bits, root decision as MSB; leaf_index equals the final node number minus 63.
REQ-021 SHALL be fully pipelined with one tree level per stage.
REQ-022 SHALL accept a new patch every cycle, with no backpressure.
REQ-023 SHALL present the result 6 cycles after patch_en is sampled, with receiver_en high for exactly that one cycle.
REQ-024 SHALL deliver results in input order.
REQ-025 SHALL hold leaf_index at its last value while receiver_en is low.
REQ-026 SHALL let a traversal in the same cycle as a node write read the old node contents; the write becomes visible the next cycle.
REQ-027 SHALL give a patch issued before loading completes the current (possibly partial or zero) node contents; this is not an error.

Reset
REQ-028 SHALL, on rst_n low, immediately clear leaf_index, receiver_en, wr_ptr, all pipeline valid bits, and all node storage to 0.
REQ-029 SHALL discard in-flight patches on reset mid-operation; no receiver_en follows for them.

Structure
REQ-030 SHALL place constants DIM_WIDTH=11, NUM_DIMS=5, TREE_DEPTH=6, NUM_NODES=63 and the node-word field layout in shared package kd_tree_pkg.
REQ-031 SHALL implement one level as sub-module tree_level_stage, instantiated 6 times: node lookup, component select, compare, path update, valid and patch forwarding.

Verification
REQ-032 All nodes {median=0, dim=0}, patch comp0=+5 -> leaf_index=63 with receiver_en 6 cycles later.
REQ-033 Same tree, comp0=-5 -> leaf 0; comp0=0 -> leaf 0 (tie goes left).
REQ-034 Root {median=100, dim=2}, all other nodes {median=0, dim=0}, patch [0,0,101,0,0] -> leaf 32; patch [1,0,100,0,0] -> leaf 31.
REQ-035 Three patches on consecutive cycles [5,...], [-5,...], [5,...] on the all-zero tree -> receiver_en on 3 consecutive cycles, leaves 63, 0, 63.
REQ-036 Load 70 words -> only the first 63 are stored. Drop fsm_enable and send further words -> node contents unchanged.
REQ-037 Assert rst_n low with 2 patches in flight -> no receiver_en, leaf_index=0, and a subsequent reload works from node 0.
